// File: rtl/if_pkg.sv
// if_pkg: shared FSM state type and parameter defaults for the instruction prefetch unit
package if_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;
    localparam logic [3:0] HALT_OP_DEF = 4'hF;
    localparam int PC_STEP_DEF = 2;
endpackage

// File: rtl/if_prefetch_if.sv
// if_prefetch_if: instruction-memory, redirect and decode-side signals of the prefetch unit
interface if_prefetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              halted;
    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, halted,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, halted,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two circular FIFO with synchronous flush; head reads as zero when empty
module fetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_cnt;
    assign o_valid = r_cnt != '0;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;
    // entry storage; a flush discards any same-cycle write
    always_ff @(posedge clk)
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{PTR_W{1'b0}}, i_push} - {{PTR_W{1'b0}}, i_pop};
        end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: single-outstanding instruction fetcher feeding decode through a small queue
module if_prefetch
    import if_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = HALT_OP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    if_prefetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_fetch_pc;
    logic [ADDR_W-1:0]        w_pc_nxt;
    logic                     r_discard;
    logic                     w_discard_nxt;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_q_valid;
    logic [PTR_W:0]           w_count;
    logic [DATA_W+ADDR_W-1:0] w_q_data;
    assign w_pop         = w_q_valid & bus.id_ready & ~bus.redirect_valid;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.id_valid  = w_q_valid;
    assign bus.id_pc     = w_q_data[DATA_W +: ADDR_W];
    assign bus.id_instr  = w_q_data[DATA_W-1:0];
    assign bus.halted    = (r_state == ST_HALT) & ~w_q_valid;
    fetch_queue #(
        .W     (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_fetch_pc, bus.imem_rdata}),
        .i_pop   (w_pop),
        .o_valid (w_q_valid),
        .o_data  (w_q_data),
        .o_count (w_count)
    );
    // next state, fetch address, discard flag, push and request; redirect overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_fetch_pc;
        w_discard_nxt = r_discard;
        w_push        = 1'b0;
        bus.imem_req  = 1'b0;
        if (bus.redirect_valid) begin
            w_pc_nxt      = bus.redirect_pc;
            w_state_nxt   = ST_RUN;
            w_discard_nxt = 1'b0;
            if (r_state == ST_WAIT && !bus.imem_rvalid) begin
                w_state_nxt   = ST_WAIT;
                w_discard_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                ST_RUN: if (rst_n && w_count < FULL) begin
                    bus.imem_req = 1'b1;
                    w_state_nxt  = ST_WAIT;
                end
                ST_WAIT: if (bus.imem_rvalid) begin
                    w_state_nxt   = ST_RUN;
                    w_discard_nxt = 1'b0;
                    if (!r_discard) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_fetch_pc + ADDR_W'(PC_STEP);
                        if (bus.imem_rdata[DATA_W-1 -: 4] == HALT_OP) w_state_nxt = ST_HALT;
                    end
                end
                default: ;
            endcase
        end
    end
    // state, fetch address and discard registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_discard  <= w_discard_nxt;
        end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed scenarios plus random traffic against an epoch-based transaction model
module tb_if_prefetch;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DEPTH = 4;
    localparam int STEP = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_q [$];
    logic [15:0] m_pc;
    logic [15:0] m_out_addr;
    bit          m_out;
    bit          m_halt;
    int          m_epoch;
    int          m_out_epoch;
    bit          mem_pend;
    logic [15:0] mem_addr;
    int          mem_dly;
    int          mem_lat;
    bit          rand_data;
    bit          spurious_en;
    logic [15:0] halt_addr;
    logic [15:0] req_log [$];
    logic [15:0] pop_log [$];
    logic        o_req;
    logic        o_valid;
    logic        o_halt;
    logic [15:0] o_addr;
    logic [15:0] o_pc;
    int          np;
    always #5 clk = ~clk;
    if_prefetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    if_prefetch #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .PC_STEP  (STEP),
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == halt_addr) ? 16'hF000 : {1'b0, a[14:0] ^ 15'h2A5C};
    endfunction
    function automatic logic [15:0] rand_ins();
        logic [3:0] op;
        op = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        return {op, 12'($urandom)};
    endfunction
    task automatic model_reset();
        m_q.delete();
        m_pc = 16'h0000;
        m_out = 0;
        m_halt = 0;
        m_epoch = 0;
        m_out_epoch = 0;
        mem_pend = 0;
        req_log.delete();
        pop_log.delete();
    endtask
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.id_ready = 1'b0;
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_instr", 32'(bus.id_instr), 32'd0);
        chk("rst_pc", 32'(bus.id_pc), 32'd0);
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask
    task automatic step(input bit redir, input logic [15:0] rpc, input bit rdy);
        bit rv;
        bit e_req;
        bit pop;
        logic [15:0] rd;
        @(negedge clk);
        rv = 0;
        rd = 16'($urandom);
        if (mem_pend && mem_dly == 0) begin
            rv = 1;
            rd = rand_data ? rand_ins() : mem_word(mem_addr);
        end else if (!mem_pend && spurious_en && $urandom_range(0, 9) == 0) rv = 1;
        if (mem_pend && mem_dly > 0) mem_dly--;
        bus.redirect_valid = redir;
        bus.redirect_pc = rpc;
        bus.id_ready = rdy;
        bus.imem_rvalid = rv;
        bus.imem_rdata = rd;
        #1;
        e_req = !m_out && !m_halt && m_q.size() < DEPTH && !redir;
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        if (e_req && bus.imem_req) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("id_valid", 32'(bus.id_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0 && bus.id_valid) begin
            chk("id_pc", 32'(bus.id_pc), 32'(m_q[0][31:16]));
            chk("id_instr", 32'(bus.id_instr), 32'(m_q[0][15:0]));
        end
        chk("halted", 32'(bus.halted), 32'(m_halt && m_q.size() == 0));
        o_req = bus.imem_req;
        o_addr = bus.imem_addr;
        o_valid = bus.id_valid;
        o_pc = bus.id_pc;
        o_halt = bus.halted;
        pop = m_q.size() != 0 && rdy && !redir;
        @(posedge clk);
        if (pop) pop_log.push_back(m_q[0][31:16]);
        if (redir) begin
            m_q.delete();
            m_pc = rpc;
            m_halt = 0;
            m_epoch++;
        end else if (pop) void'(m_q.pop_front());
        if (rv && m_out) begin
            m_out = 0;
            if (m_out_epoch == m_epoch) begin
                m_q.push_back({m_out_addr, rd});
                m_pc = m_out_addr + 16'(STEP);
                if (rd[15:12] == 4'hF) m_halt = 1;
            end
        end
        if (e_req) begin
            m_out = 1;
            m_out_addr = m_pc;
            m_out_epoch = m_epoch;
            req_log.push_back(m_pc);
        end
        if (rv) mem_pend = 0;
        if (o_req) begin
            mem_pend = 1;
            mem_addr = o_addr;
            mem_dly = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
    endtask
    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.id_ready = 1'b0;
        mem_lat = 0;
        rand_data = 0;
        spurious_en = 0;
        halt_addr = 16'h0001;
        model_reset();
        // streaming with a 1-cycle memory
        do_reset(2);
        repeat (12) step(0, 16'h0, 1);
        chk("s1_req0", 32'(req_log[0]), 32'h0000);
        chk("s1_req1", 32'(req_log[1]), 32'h0002);
        chk("s1_req2", 32'(req_log[2]), 32'h0004);
        chk("s1_nreq", 32'(req_log.size()), 32'd6);
        chk("s1_npop", 32'(pop_log.size()), 32'd5);
        chk("s1_pop4", 32'(pop_log[4]), 32'h0008);
        // decode stalled: queue fills then fetch stops
        do_reset(1);
        repeat (16) step(0, 16'h0, 0);
        chk("s2_nreq", 32'(req_log.size()), 32'd4);
        chk("s2_req_off", 32'(o_req), 32'd0);
        chk("s2_head_valid", 32'(o_valid), 32'd1);
        chk("s2_head_pc", 32'(o_pc), 32'h0000);
        repeat (4) step(0, 16'h0, 1);
        for (int i = 0; i < 4; i++) chk("s2_drain", 32'(pop_log[i]), 32'(i * 2));
        // redirect while waiting on 0x0006, stale response arrives later
        do_reset(1);
        mem_lat = 2;
        for (int i = 0; i < 60 && req_log.size() < 4; i++) step(0, 16'h0, 1);
        chk("s3_reach6", 32'(req_log[3]), 32'h0006);
        step(1, 16'h0100, 1);
        np = pop_log.size();
        repeat (10) step(0, 16'h0, 1);
        chk("s3_next_req", 32'(req_log[4]), 32'h0100);
        chk("s3_first_pc", 32'(pop_log[np]), 32'h0100);
        // redirect coincident with response and pop
        do_reset(1);
        mem_lat = 0;
        for (int i = 0; i < 40 && !(m_q.size() >= 2 && mem_pend && mem_dly == 0); i++) step(0, 16'h0, 0);
        chk("s4_setup", 32'(m_q.size() >= 2 && mem_pend), 32'd1);
        step(1, 16'h0040, 1);
        step(0, 16'h0, 1);
        chk("s4_empty", 32'(o_valid), 32'd0);
        chk("s4_req", 32'(o_req), 32'd1);
        chk("s4_addr", 32'(o_addr), 32'h0040);
        // halt opcode at 0x0008, resume by redirect
        do_reset(1);
        halt_addr = 16'h0008;
        repeat (20) step(0, 16'h0, 1);
        chk("s5_nreq", 32'(req_log.size()), 32'd5);
        chk("s5_last", 32'(req_log[4]), 32'h0008);
        chk("s5_noreq", 32'(o_req), 32'd0);
        chk("s5_halted", 32'(o_halt), 32'd1);
        step(1, 16'h0020, 1);
        step(0, 16'h0, 1);
        chk("s5_resume", 32'(o_req), 32'd1);
        chk("s5_addr", 32'(o_addr), 32'h0020);
        chk("s5_unhalt", 32'(o_halt), 32'd0);
        halt_addr = 16'h0001;
        // address wrap-around
        do_reset(1);
        step(1, 16'hFFFE, 1);
        repeat (8) step(0, 16'h0, 1);
        chk("s6_req0", 32'(req_log[0]), 32'hFFFE);
        chk("s6_req1", 32'(req_log[1]), 32'h0000);
        // random traffic
        mem_lat = -1;
        rand_data = 1;
        spurious_en = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
            else step($urandom_range(0, 19) == 0, 16'($urandom) & 16'hFFFE, $urandom_range(0, 9) < 7);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction width.
REQ-002 SHALL have parameter ADDR_W, default 16, PC/address width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-004 SHALL have parameter PC_STEP, default 2, byte increment per instruction.
REQ-005 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-006 SHALL have parameter HALT_OP, default 4'hF, opcode value in instr[DATA_W-1 -: 4] that marks halt.
REQ-007 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port imem_req  out  1  fetch request; accepted in the cycle it is high.
REQ-010 SHALL have port imem_addr  out  ADDR_W  fetch address.
REQ-011 SHALL have port imem_rvalid  in  1  response valid; in order; at least 1 cycle after request.
REQ-012 SHALL have port imem_rdata  in  DATA_W  response instruction.
REQ-013 SHALL have port redirect_valid  in  1  branch/flush request.
REQ-014 SHALL have port redirect_pc  in  ADDR_W  new fetch address.
REQ-015 SHALL have port id_ready  in  1  decode accepts head (stall_n).
REQ-016 SHALL have port id_valid  out  1  queue head valid.
REQ-017 SHALL have port id_instr  out  DATA_W  head instruction.
REQ-018 SHALL have port id_pc  out  ADDR_W  head instruction address.
REQ-019 SHALL have port halted  out  1  halt fetched, queue drained.

Function
REQ-020 SHALL implement the FSM states RUN, WAIT and HALT, with at most one outstanding request.
REQ-021 In RUN with count<DEPTH: imem_req=1, imem_addr=fetch_pc, next state WAIT; otherwise imem_req=0.
REQ-022 In WAIT with rvalid and no discard: push {fetch_pc, rdata}, advance fetch_pc by PC_STEP modulo 2^ADDR_W, and go to HALT if the opcode equals HALT_OP, else RUN.
REQ-023 Pushed entry SHALL appear on id_* no earlier than the cycle after rvalid; the block has no bypass path.
REQ-024 id_valid = queue non-empty; pop occurs when id_valid & id_ready; id_instr/id_pc SHALL hold stable while id_valid & ~id_ready.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; overflow is impossible because requests are gated on count<DEPTH; queue pointers wrap modulo DEPTH.
REQ-026 Redirect has highest priority: queue flushed (id_valid=0 next cycle), fetch_pc=redirect_pc, any same-cycle pop or push suppressed.
REQ-027 Redirect in WAIT without same-cycle rvalid: set discard and stay in WAIT; the next rvalid is dropped, clears discard, and moves to RUN.
REQ-028 Redirect in WAIT with same-cycle rvalid: response dropped, discard stays 0, next state RUN.
REQ-029 Redirect in RUN or HALT: next state RUN, and the first request to redirect_pc occurs the following cycle.
REQ-030 HALT: no requests; exit only on redirect; halted=1 iff state HALT and queue empty.
REQ-031 rvalid outside WAIT SHALL be ignored, with no push and no state change.

Reset
REQ-032 While rst_n=0: state RUN, fetch_pc=RESET_PC, count/pointers/discard 0, imem_req=0, id_valid=0, halted=0, id_instr=0, id_pc=0.
REQ-033 The first imem_req to RESET_PC SHALL occur in the first cycle after rst_n rises; reset asserted mid-WAIT abandons the request, and any later stale rvalid falls under REQ-031.

Structure
REQ-034 Package if_pkg SHALL hold the FSM state enum, the HALT_OP default and the PC_STEP default.
REQ-035 The queue SHALL be a sub-module fetch_queue (parametrised DATA_W+ADDR_W wide, DEPTH deep, with synchronous flush).

Verification
REQ-036 The bench SHALL cover this scenario: reset release, 1-cycle memory, id_ready=1 -> requests 0x0000,0x0002,0x0004...; id_pc sequence matches, one instruction per 2 cycles.
REQ-037 The bench SHALL cover this scenario: id_ready=0 with DEPTH=4 -> exactly 4 requests, then imem_req=0; id_instr/id_pc stable; on release the 4 entries drain in order.
REQ-038 The bench SHALL cover this scenario: redirect to 0x0100 while WAIT on 0x0006, rvalid 2 cycles later -> that response dropped, next request 0x0100, id_pc=0x0100 first.
REQ-039 The bench SHALL cover this scenario: redirect coincident with rvalid and a pop -> queue empty next cycle, response dropped, no discard, request to redirect_pc next cycle.
REQ-040 The bench SHALL cover this scenario: instruction 0xF000 fetched at 0x0008 -> no further requests, halted=1 once drained; redirect to 0x0020 resumes fetching.
REQ-041 The bench SHALL cover this scenario: redirect_pc=0xFFFE -> fetches 0xFFFE then 0x0000 (wrap-around).
